// File: rtl/complex_frame_pingpong_ram_if.sv
// Sample stream interface for the complex ping-pong frame buffer.
// The master drives input samples and control; the slave returns the replayed frame.
interface complex_frame_pingpong_ram_if #(
  parameter int total_bits = 32
);
  logic                  ED;
  logic                  START;
  logic                  SPLIT;
  logic [total_bits-1:0] DReal;
  logic [total_bits-1:0] DImag;
  logic [total_bits-1:0] DOReal;
  logic [total_bits-1:0] DOImag;
  logic                  VALID;
  logic                  RDY;
  logic                  BUSY;

  modport master (
    output ED, START, SPLIT, DReal, DImag,
    input  DOReal, DOImag, VALID, RDY, BUSY
  );

  modport slave (
    input  ED, START, SPLIT, DReal, DImag,
    output DOReal, DOImag, VALID, RDY, BUSY
  );
endinterface

// File: rtl/complex_frame_pingpong_ram.sv
// Ping-pong frame buffer for complex samples: natural or even/odd replay.
// Define BITREV_EN to make SPLIT=0 replay in bit-reversed order instead.
module complex_frame_pingpong_ram #(
  parameter int total_bits = 32,
  parameter int ADDR_BITS  = 4
) (
  input  logic CLK,
  input  logic RST,
  complex_frame_pingpong_ram_if.slave bus
);
  localparam int N = 1 << ADDR_BITS;
  localparam int W = 2 * total_bits;

  typedef logic [ADDR_BITS-1:0] addr_t;

  logic [W-1:0] mem [2*N];

  addr_t wct;
  addr_t rct;
  addr_t waddr;
  addr_t raddr;
  logic  busy;
  logic  ract;
  logic  wbank;
  logic  rbank;
  logic  split_q;
  logic  valid;
  logic  rdy;
  logic  we;
  logic  last_w;
  logic  swap;
  logic [total_bits-1:0] dore;
  logic [total_bits-1:0] doim;

  function automatic addr_t map_addr(
    input addr_t r,
    input logic  sp
  );
    addr_t b;
    b = r;
    if (sp) begin
      b = {r[ADDR_BITS-2:0], r[ADDR_BITS-1]};
    end else begin
`ifdef BITREV_EN
      for (int i = 0; i < ADDR_BITS; i++)
        b[i] = r[ADDR_BITS-1-i];
`else
      b = r;
`endif
    end
    return b;
  endfunction

  // START wins over completion: a restart on the last index never swaps
  always_comb begin
    we     = bus.ED && (bus.START || busy);
    waddr  = bus.START ? '0 : wct;
    last_w = busy && !bus.START
          && (wct == addr_t'(N-1));
    swap   = bus.ED && last_w;
    raddr  = map_addr(rct, split_q);
  end

  always_ff @(posedge CLK) begin
    if (we)
      mem[{wbank, waddr}] <=
        {bus.DReal, bus.DImag};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wct     <= '0;
      rct     <= '0;
      busy    <= 1'b0;
      ract    <= 1'b0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      split_q <= 1'b0;
      valid   <= 1'b0;
      rdy     <= 1'b0;
      dore    <= '0;
      doim    <= '0;
    end else if (bus.ED) begin
      if (bus.START) begin
        wct  <= addr_t'(1);
        busy <= 1'b1;
      end else if (busy) begin
        wct <= wct + addr_t'(1);
        if (last_w) begin
          busy  <= 1'b0;
          wct   <= '0;
          wbank <= ~wbank;
        end
      end
      if (ract) begin
        {dore, doim} <= mem[{rbank, raddr}];
        valid <= 1'b1;
        rdy   <= (rct == '0);
        rct   <= rct + addr_t'(1);
        if (rct == addr_t'(N-1))
          ract <= 1'b0;
      end else begin
        valid <= 1'b0;
        rdy   <= 1'b0;
      end
      // a swap on the final read edge restarts replay seamlessly
      if (swap) begin
        ract    <= 1'b1;
        rct     <= '0;
        split_q <= bus.SPLIT;
        rbank   <= wbank;
      end
    end
  end

  assign bus.DOReal = dore;
  assign bus.DOImag = doim;
  assign bus.VALID  = valid;
  assign bus.RDY    = rdy;
  assign bus.BUSY   = busy;
endmodule
